// File: rtl/bcd_digit_counter.sv
// Two-digit BCD counter with synchronous load, terminal-count flag for cascading,
// and a load-reject pulse. Define BCD_CNT_DOWN_EN to enable up/down counting via up_dn.
module bcd_digit_counter #(
  parameter logic [3:0] WRAP_HI = 4'd9,
  parameter logic [3:0] WRAP_LO = 4'd9
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       ld,
  input  logic [7:0] ld_dat,
  input  logic       up_dn,
  output logic [7:0] dat_out,
  output logic       tc,
  output logic       err
);

  localparam logic [7:0] TERM = {WRAP_HI, WRAP_LO};

  logic [7:0] cnt_q, cnt_d;
  logic       err_q, err_d;
  logic [7:0] up_nxt;
  logic       ld_ok;
  logic       at_top;

  assign ld_ok  = (ld_dat[7:4] <= 4'd9) && (ld_dat[3:0] <= 4'd9);
  // With valid BCD nibbles, a plain unsigned compare orders values numerically.
  assign at_top = (cnt_q >= TERM);

  always_comb begin
    up_nxt = cnt_q;
    if (at_top) begin
      up_nxt = 8'h00;
    end else if (cnt_q[3:0] == 4'd9) begin
      up_nxt = {cnt_q[7:4] + 4'd1, 4'd0};
    end else begin
      up_nxt = {cnt_q[7:4], cnt_q[3:0] + 4'd1};
    end
  end

`ifdef BCD_CNT_DOWN_EN
  logic [7:0] dn_nxt;
  logic       at_zero;

  assign at_zero = (cnt_q == 8'h00);

  always_comb begin
    dn_nxt = cnt_q;
    if (at_zero) begin
      dn_nxt = TERM;
    end else if (cnt_q[3:0] == 4'd0) begin
      dn_nxt = {cnt_q[7:4] - 4'd1, 4'd9};
    end else begin
      dn_nxt = {cnt_q[7:4], cnt_q[3:0] - 4'd1};
    end
  end

  assign tc = en & ~ld & (up_dn ? at_top : at_zero);
`else
  logic unused_up_dn;
  assign unused_up_dn = up_dn;
  assign tc = en & ~ld & at_top;
`endif

  always_comb begin
    cnt_d = cnt_q;
    err_d = 1'b0;
    if (ld) begin
      // A rejected load holds the count and swallows en for this cycle.
      if (ld_ok) begin
        cnt_d = ld_dat;
      end else begin
        err_d = 1'b1;
      end
    end else if (en) begin
`ifdef BCD_CNT_DOWN_EN
      cnt_d = up_dn ? up_nxt : dn_nxt;
`else
      cnt_d = up_nxt;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 8'h00;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign dat_out = cnt_q;
  assign err     = err_q;

endmodule

// File: tb/tb_bcd_digit_counter.sv
// Scoreboard bench for bcd_digit_counter: two instances (wrap 99 and wrap 59) share
// stimulus; an integer-arithmetic model predicts count, err and tc every cycle.
module tb_bcd_digit_counter;

  localparam int W = 20;

`ifdef BCD_CNT_DOWN_EN
  localparam bit DOWN_EN = 1'b1;
`else
  localparam bit DOWN_EN = 1'b0;
`endif

  // ---------------- clock / reset / DUTs ----------------
  logic       clk    = 1'b0;
  logic       rst_n  = 1'b0;
  logic       en     = 1'b0;
  logic       ld     = 1'b0;
  logic [7:0] ld_dat = 8'h00;
  logic       up_dn  = 1'b1;

  logic [7:0] dat_a, dat_b;
  logic       tc_a, tc_b, err_a, err_b;

  always #5 clk = ~clk;

  bcd_digit_counter u_dut_99 (
    .clk(clk), .rst_n(rst_n), .en(en), .ld(ld), .ld_dat(ld_dat), .up_dn(up_dn),
    .dat_out(dat_a), .tc(tc_a), .err(err_a)
  );

  bcd_digit_counter #(.WRAP_HI(4'd5), .WRAP_LO(4'd9)) u_dut_59 (
    .clk(clk), .rst_n(rst_n), .en(en), .ld(ld), .ld_dat(ld_dat), .up_dn(up_dn),
    .dat_out(dat_b), .tc(tc_b), .err(err_b)
  );

  // ---------------- reference model ----------------
  int val[2];
  bit er[2];
  int term[2];

  logic [W-1:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  function automatic logic [7:0] to_bcd(input int v);
    logic [3:0] h, l;
    h = 4'(v / 10);
    l = 4'(v % 10);
    return {h, l};
  endfunction

  function automatic logic [3:0] xs3(input logic [3:0] n);
    case (n)
      4'd0: return 4'd3;   4'd1: return 4'd4;   4'd2: return 4'd5;
      4'd3: return 4'd6;   4'd4: return 4'd7;   4'd5: return 4'd8;
      4'd6: return 4'd9;   4'd7: return 4'd10;  4'd8: return 4'd11;
      4'd9: return 4'd12;
      default: return 4'd0;
    endcase
  endfunction

  // Advance the model by the inputs present on the pins at the edge just taken.
  function automatic void model_edge();
    int hi, lo;
    bit go_up;
    hi    = int'(ld_dat[7:4]);
    lo    = int'(ld_dat[3:0]);
    go_up = DOWN_EN ? up_dn : 1'b1;
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        val[i] = 0;
        er[i]  = 0;
      end else if (ld) begin
        if (hi <= 9 && lo <= 9) begin
          val[i] = 10 * hi + lo;
          er[i]  = 0;
        end else begin
          er[i] = 1;
        end
      end else begin
        er[i] = 0;
        if (en) begin
          if (go_up) val[i] = (val[i] >= term[i]) ? 0 : val[i] + 1;
          else       val[i] = (val[i] == 0) ? term[i] : val[i] - 1;
        end
      end
    end
  endfunction

  function automatic logic [9:0] expect_of(input int i);
    bit go_up, t;
    go_up = DOWN_EN ? up_dn : 1'b1;
    t = en && !ld && (go_up ? (val[i] >= term[i]) : (val[i] == 0));
    return {t, er[i], to_bcd(val[i])};
  endfunction

  // ---------------- driver ----------------
  task automatic cycle(input logic e, input logic l, input logic [7:0] d,
                       input logic u, input logic r);
    @(posedge clk);
    #2;
    model_edge();
    en = e; ld = l; ld_dat = d; up_dn = u; rst_n = r;
    if (!r) begin
      for (int i = 0; i < 2; i++) begin
        val[i] = 0;
        er[i]  = 0;
      end
    end
    exp_q.push_back({expect_of(1), expect_of(0)});
  endtask

  task automatic run_en(input int n, input logic u);
    for (int k = 0; k < n; k++) cycle(1'b1, 1'b0, 8'h00, u, 1'b1);
  endtask

  // ---------------- scoreboard / monitor ----------------
  function automatic void chk(input string name, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s at t=%0t: got %0h, expected %0h", name, $time, got, want);
    end
  endfunction

  function automatic void chk_nibbles(input string name, input logic [7:0] d);
    chk({name, "_hi_bcd"}, int'(d[7:4] <= 4'd9), 1);
    chk({name, "_lo_bcd"}, int'(d[3:0] <= 4'd9), 1);
    chk({name, "_hi_xs3"}, int'(xs3(d[7:4])), int'(d[7:4]) + 3);
    chk({name, "_lo_xs3"}, int'(xs3(d[3:0])), int'(d[3:0]) + 3);
  endfunction

  initial begin
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      chk_nibbles("w99", dat_a);
      chk_nibbles("w59", dat_b);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("w99_dat", int'(dat_a), int'(e[7:0]));
        chk("w99_err", int'(err_a), int'(e[8]));
        chk("w99_tc",  int'(tc_a),  int'(e[9]));
        chk("w59_dat", int'(dat_b), int'(e[17:10]));
        chk("w59_err", int'(err_b), int'(e[18]));
        chk("w59_tc",  int'(tc_b),  int'(e[19]));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] d;
    term[0] = 99;
    term[1] = 59;
    for (int i = 0; i < 2; i++) begin
      val[i] = 0;
      er[i]  = 0;
    end

    // Held in reset, then released idle.
    cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);

    // Full up-count run through 99 and back to 00.
    run_en(101, 1'b1);

    // Load 58 and count across the 59 wrap.
    cycle(1'b0, 1'b1, 8'h58, 1'b1, 1'b1);
    run_en(3, 1'b1);

    // Rejected load, then a valid one above the 59 terminal count.
    cycle(1'b1, 1'b1, 8'h3A, 1'b1, 1'b1);
    cycle(1'b0, 1'b1, 8'h72, 1'b1, 1'b1);
    cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    run_en(2, 1'b1);
    cycle(1'b1, 1'b1, 8'hA3, 1'b1, 1'b1);
    cycle(1'b0, 1'b1, 8'hFF, 1'b1, 1'b1);

    // Down-direction request from 10 across zero.
    cycle(1'b0, 1'b1, 8'h10, 1'b0, 1'b1);
    run_en(13, 1'b0);

    // Load wins over en; then reset asserted between edges mid-count.
    cycle(1'b1, 1'b1, 8'h45, 1'b1, 1'b1);
    run_en(2, 1'b1);
    cycle(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 8'h00, 1'b1, 1'b1);
    run_en(3, 1'b1);

    // Randomized traffic.
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 1) == 0)
        d = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      else
        d = 8'($urandom_range(0, 255));
      cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 9) == 0), d,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 59) != 0));
    end

    @(negedge clk);
    @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
